// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//    Sequencing FSM for a 2-way, write-back L1 cache. It takes CPU read and
//    write requests, decides hit or miss from the datapath's tag compare, and
//    drives the datapath's array write enables and mux selects. On a miss it
//    evicts a dirty victim (WRITEBACK), refills the line (ALLOCATE), then
//    re-checks so the request completes through the normal hit path. Three
//    saturating counters track hits, misses and writebacks.
//
// Ports
//    clk, rst_n                  clock, asynchronous active-low reset
//    mem_read, mem_write         CPU request, held until mem_resp
//    mem_resp                    one-cycle completion pulse to the CPU
//    hit0, hit1                  per-way tag match AND valid (meaningful in CHECK)
//    dirty0, dirty1, lru         indexed-set array outputs; lru = way to evict
//    pmem_read, pmem_write       physical-memory request, held until pmem_resp
//    pmem_resp                   physical-memory completion pulse
//    load_data0/1, load_tag0/1,
//    load_valid0/1, load_dirty0/1,
//    load_lru                    array write enables
//    dirty_in, lru_in            values written with load_dirty* / load_lru
//    data_sel                    0 = line from pmem, 1 = merged write line
//    way_sel                     way routed to mem_rdata / pmem_wdata
//    pmem_addr_sel               0 = CPU line address, 1 = victim {tag, index}
//    clear_counts                synchronous counter clear
//    hit_count, miss_count,
//    wb_count                    saturating event counters
// ---------------------------------------------------------------------------
module cache_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   input  logic             hit0,
   input  logic             hit1,
   input  logic             dirty0,
   input  logic             dirty1,
   input  logic             lru,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   output logic             load_data0,
   output logic             load_data1,
   output logic             load_tag0,
   output logic             load_tag1,
   output logic             load_valid0,
   output logic             load_valid1,
   output logic             load_dirty0,
   output logic             load_dirty1,
   output logic             load_lru,
   output logic             dirty_in,
   output logic             lru_in,
   output logic             data_sel,
   output logic             way_sel,
   output logic             pmem_addr_sel,
   input  logic             clear_counts,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHECK     = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } state_t;

   state_t state, next_state;
   logic   victim_q;
   logic   refill_q;

   logic   request;
   logic   any_hit;
   logic   hit_way;
   logic   victim_dirty;
   logic   hit_event;
   logic   miss_event;
   logic   wb_event;
   logic   fill_done;

   assign request      = mem_read | mem_write;
   assign any_hit      = hit0 | hit1;
   // Way 0 wins when both ways report a hit.
   assign hit_way      = ~hit0;
   assign victim_dirty = lru ? dirty1 : dirty0;

   // Next-state and output decode. Everything defaults to 0 so any output
   // not explicitly driven in a state stays low.
   always_comb begin
      next_state    = state;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      load_data0    = 1'b0;
      load_data1    = 1'b0;
      load_tag0     = 1'b0;
      load_tag1     = 1'b0;
      load_valid0   = 1'b0;
      load_valid1   = 1'b0;
      load_dirty0   = 1'b0;
      load_dirty1   = 1'b0;
      load_lru      = 1'b0;
      dirty_in      = 1'b0;
      lru_in        = 1'b0;
      data_sel      = 1'b0;
      way_sel       = 1'b0;
      pmem_addr_sel = 1'b0;
      hit_event     = 1'b0;
      miss_event    = 1'b0;
      wb_event      = 1'b0;
      fill_done     = 1'b0;

      unique case (state)
         IDLE: begin
            if (request) next_state = CHECK;
         end

         CHECK: begin
            if (!request) begin
               next_state = IDLE;
            end else if (any_hit) begin
               mem_resp   = 1'b1;
               way_sel    = hit_way;
               load_lru   = 1'b1;
               lru_in     = ~hit_way;
               // The re-check after a refill is not a real hit.
               hit_event  = ~refill_q;
               if (mem_write) begin
                  load_data0  = ~hit_way;
                  load_data1  = hit_way;
                  load_dirty0 = ~hit_way;
                  load_dirty1 = hit_way;
                  data_sel    = 1'b1;
                  dirty_in    = 1'b1;
               end
               next_state = IDLE;
            end else begin
               miss_event = 1'b1;
               next_state = victim_dirty ? WRITEBACK : ALLOCATE;
            end
         end

         // The victim way comes from victim_q, not lru, because the LRU
         // array output may change while the transaction is in flight.
         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel       = victim_q;
            if (pmem_resp) begin
               wb_event   = 1'b1;
               next_state = ALLOCATE;
            end
         end

         ALLOCATE: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               fill_done   = 1'b1;
               load_data0  = ~victim_q;
               load_data1  = victim_q;
               load_tag0   = ~victim_q;
               load_tag1   = victim_q;
               load_valid0 = ~victim_q;
               load_valid1 = victim_q;
               load_dirty0 = ~victim_q;
               load_dirty1 = victim_q;
               next_state  = CHECK;
            end
         end

         default: next_state = IDLE;
      endcase
   end

   // State register plus the victim way and the refill flag that suppresses
   // the hit count on the re-check following an ALLOCATE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         victim_q <= 1'b0;
         refill_q <= 1'b0;
      end else begin
         state <= next_state;
         if (miss_event) victim_q <= lru;
         if (fill_done) begin
            refill_q <= 1'b1;
         end else if (state == CHECK) begin
            refill_q <= 1'b0;
         end
      end
   end

   // Saturating performance counters; clear_counts beats a same-cycle event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else if (clear_counts) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (hit_event  && (hit_count  != '1)) hit_count  <= hit_count  + CNT_W'(1);
         if (miss_event && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
         if (wb_event   && (wb_count   != '1)) wb_count   <= wb_count   + CNT_W'(1);
      end
   end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way, write-back L1 cache datapath; the datapath contains the tag/valid/dirty/LRU arrays, the 256-bit data arrays and the write-merge unit. The block accepts CPU read/write requests and decides on hit or miss. It commands the datapath's array loads and multiplexer selects, runs the physical-memory writeback and allocate handshakes, and keeps saturating hit/miss/writeback counters.

## Interface
- CNT_W, 32, width of each performance counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read, mem_write  in  1 each  CPU request; held until mem_resp; never both set
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit0, hit1  in  1 each  way tag match AND valid, from datapath (valid in CHECK)
- dirty0, dirty1, lru  in  1 each  array outputs for the indexed set; lru = way to evict
- pmem_read, pmem_write  out  1 each  physical-memory request, held until pmem_resp
- pmem_resp  in  1  physical-memory completion pulse
- load_data0/1, load_tag0/1, load_valid0/1, load_dirty0/1, load_lru  out  1 each  array write enables
- dirty_in, lru_in  out  1 each  value written on load_dirty*/load_lru
- data_sel  out  1  data-array input: 0 = line from pmem, 1 = merged line from write-merge unit
- way_sel  out  1  way routed to mem_rdata and pmem_wdata
- pmem_addr_sel  out  1  0 = CPU line address, 1 = victim {tag, index}
- clear_counts  in  1  synchronous counter clear
- hit_count, miss_count, wb_count  out  CNT_W each  saturating event counters

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE. Outputs are combinational from state, inputs and victim_q; undriven outputs are 0.
- IDLE: mem_read|mem_write -> CHECK; otherwise stay.
- CHECK, no request present: -> IDLE with no array or counter update.
- CHECK, hit (hit0|hit1; hit0 wins if both set): mem_resp=1 and way_sel=hit way. load_lru=1 with lru_in = other way. On a write, also load_data[way]=1, data_sel=1, load_dirty[way]=1 and dirty_in=1. Next state is IDLE.
- CHECK, miss: victim_q <= lru. Next state is WRITEBACK if dirty[lru], else ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim_q. On pmem_resp the FSM goes to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0. On pmem_resp the block asserts load_data/load_tag/load_valid/load_dirty[victim_q]=1 with data_sel=0 and dirty_in=0, then goes to CHECK. The re-check then hits and completes the request, including the write merge.
- refill_q is set on ALLOCATE exit and cleared on CHECK exit.
- Counters:
  - hit_count increments on a CHECK hit with refill_q=0.
  - miss_count increments on a CHECK miss.
  - wb_count increments on WRITEBACK exit.
  - Counters saturate at all-ones.
  - clear_counts has priority over an increment in the same cycle.
- A pmem transaction, once started, completes even if the CPU request drops.

## Timing
- Reset (async assert): state=IDLE, victim_q=0, refill_q=0, counters=0. Consequently every output is 0 during and immediately after reset. Reset mid-transaction drops pmem_read/pmem_write at once and abandons the transaction.
- Hit latency: request sampled in IDLE at cycle 0, mem_resp at cycle 1. The next request is accepted in IDLE at cycle 2.
- Clean miss latency: IDLE, CHECK, ALLOCATE (N cycles until pmem_resp), CHECK with mem_resp. Total N+3 cycles.
- Dirty miss adds WRITEBACK for M cycles until its pmem_resp.
- pmem_resp is ignored outside WRITEBACK/ALLOCATE.
- mem_resp is never asserted in more than one consecutive cycle.

## Test plan
- Reset, then a read to an empty set:
  - required: miss_count=1 and pmem_read high until pmem_resp.
  - required: load_*[lru] with data_sel=0, followed next cycle by mem_resp, way_sel = filled way, hit_count=0.
- Read hit on way 1, lru=1 -> at cycle 1: mem_resp=1, way_sel=1, load_lru=1, lru_in=0, hit_count=1, no pmem activity.
- Write hit on way 0 -> load_data0=1, data_sel=1, load_dirty0=1, dirty_in=1, mem_resp=1 in the same cycle.
- Miss with lru=1 and dirty1=1, pmem_resp after 4 cycles in each phase:
  - required in WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=1.
  - required after WRITEBACK: ALLOCATE, then CHECK; wb_count=1 and miss_count=1.
- Reset pulled low during ALLOCATE -> pmem_read=0 immediately, state IDLE, all counters 0.
- CNT_W=2, five read hits -> hit_count=3. Then clear_counts together with a hit -> hit_count=0.
